seq_detect_prog: RTL and testbench

Programmable serial-pattern detector, the parametrised successor to the fixed two-input 01110 detector. It accepts LANES bits per clock, with bit order MSB-first in time, and matches a runtime-loaded pattern of 1..MAX_LEN bits. It supports overlapping and non-overlapping modes, reports every in-cycle match position and keeps a saturating match counter. It sits on the serial-stream input path; its reset defaults reproduce the legacy detector's 01110, two-lane, non-overlap behaviour.

---
 rtl/seq_detect_prog.sv | 160 ++++++++++++++++
 tb/tb_seq_detect_prog.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog.sv
// Programmable serial-pattern detector: LANES bits per cycle, MSB-first in time, runtime pattern of 1..MAX_LEN bits.
// Latency: match, match_vec and match_cnt are registered, so they are visible one cycle after din is accepted.
// Backpressure: none. Always ready; din_vld=0 holds history, and any din presented with cfg_we is discarded.
module seq_detect_prog #(
   parameter  int LANES   = 2,
   parameter  int MAX_LEN = 8,
   parameter  int CNT_W   = 8,
   localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               din_vld,
   input  logic [LANES-1:0]   din,
   input  logic               cfg_we,
   input  logic [MAX_LEN-1:0] cfg_pat,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_ovl,
   input  logic               cnt_clr,
   output logic               match,
   output logic [LANES-1:0]   match_vec,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               cfg_err
);

   // History keeps enough older bits that a full-length window can end on any lane.
   localparam int HIST_W = MAX_LEN + LANES - 1;
   localparam int EXT_W  = HIST_W + LANES;
   localparam int PC_W   = $clog2(LANES + 1);
   localparam int SUM_W  = CNT_W + PC_W + 1;

   localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0]   RST_LEN = LEN_W'(5);
   localparam logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(5'b01110);
   localparam logic [SUM_W-1:0]   CNT_MAX = SUM_W'({CNT_W{1'b1}});

   // Configuration state; reset values reproduce the legacy 01110 non-overlap detector.
   logic [MAX_LEN-1:0] pat_q;
   logic [LEN_W-1:0]   len_q;
   logic               ovl_q;

   // Stream state: shifted bit history (newest bit at index 0) and count of usable start bits.
   logic [HIST_W-1:0]  hist_q;
   logic [LEN_W-1:0]   avail_q;

   logic               cfg_legal;
   logic               cfg_load;
   logic               accept;
   logic [EXT_W-1:0]   ext;
   logic [MAX_LEN-1:0] len_mask;
   logic [LANES-1:0]   win_eq;
   logic [LEN_W-1:0]   avail_walk;
   logic [LANES-1:0]   hit_vec;
   logic [LANES-1:0]   vec_d;
   logic [PC_W-1:0]    hit_cnt;
   logic [CNT_W-1:0]   cnt_base;
   logic [SUM_W-1:0]   cnt_sum;
   logic [CNT_W-1:0]   cnt_next;

   // A config write always steals the cycle; only a legal length actually loads and flushes.
   assign cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_MAX);
   assign cfg_load  = cfg_we && cfg_legal;
   assign accept    = din_vld && !cfg_we;

   // History with this cycle's lanes appended; din[0] (latest) lands at index 0.
   assign ext = {hist_q, din};

   // Mask selecting the active low len bits of the pattern and of each window.
   always_comb begin
      len_mask = '0;
      for (int b = 0; b < MAX_LEN; b++) begin
         len_mask[b] = (LEN_W'(b) < len_q);
      end
   end

   // Per-lane window compare: the window ending on din[j] starts len-1 bits earlier.
   always_comb begin
      win_eq = '0;
      for (int j = 0; j < LANES; j++) begin
         win_eq[j] = (((ext >> j) ^ EXT_W'(pat_q)) & EXT_W'(len_mask)) == '0;
      end
   end

   // Walk lanes in time order so non-overlap restarts affect the later lanes of the same cycle.
   always_comb begin
      avail_walk = avail_q;
      hit_vec    = '0;
      for (int k = 0; k < LANES; k++) begin
         if (avail_walk != LEN_MAX) begin
            avail_walk = avail_walk + LEN_W'(1);
         end
         if ((avail_walk >= len_q) && win_eq[LANES-1-k]) begin
            hit_vec[LANES-1-k] = 1'b1;
            if (!ovl_q) begin
               avail_walk = '0;
            end
         end
      end
   end

   // Matches only count on accepted cycles; idle and config cycles report nothing.
   assign vec_d = accept ? hit_vec : '0;

   // Saturating counter update; cnt_clr discards the old total but keeps this cycle's matches.
   always_comb begin
      hit_cnt = '0;
      for (int i = 0; i < LANES; i++) begin
         hit_cnt = hit_cnt + PC_W'(vec_d[i]);
      end
      cnt_base = cnt_clr ? '0 : match_cnt;
      cnt_sum  = SUM_W'(cnt_base) + SUM_W'(hit_cnt);
      if (cnt_sum > CNT_MAX) begin
         cnt_next = '1;
      end else begin
         cnt_next = cnt_sum[CNT_W-1:0];
      end
   end

   // Config registers load only on a legal write.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         pat_q <= RST_PAT;
         len_q <= RST_LEN;
         ovl_q <= 1'b0;
      end else if (cfg_load) begin
         pat_q <= cfg_pat;
         len_q <= cfg_len;
         ovl_q <= cfg_ovl;
      end
   end

   // History and availability: flushed by a legal config write, advanced on accepted data.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         hist_q  <= '0;
         avail_q <= '0;
      end else if (cfg_load) begin
         hist_q  <= '0;
         avail_q <= '0;
      end else if (accept) begin
         hist_q  <= ext[HIST_W-1:0];
         avail_q <= avail_walk;
      end
   end

   // Registered results and the one-cycle illegal-length strobe.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         match     <= 1'b0;
         match_vec <= '0;
         match_cnt <= '0;
         cfg_err   <= 1'b0;
      end else begin
         match     <= |vec_d;
         match_vec <= vec_d;
         match_cnt <= cnt_next;
         cfg_err   <= cfg_we && !cfg_legal;
      end
   end

endmodule

// File: tb/tb_seq_detect_prog.sv
module tb_seq_detect_prog;

   localparam int LANES   = 2;
   localparam int MAX_LEN = 8;
   localparam int CNT_W   = 8;
   localparam int LEN_W   = $clog2(MAX_LEN) + 1;

   logic               clk = 1'b0;
   logic               clr = 1'b1;
   logic               din_vld = 1'b0;
   logic [LANES-1:0]   din = '0;
   logic               cfg_we = 1'b0;
   logic [MAX_LEN-1:0] cfg_pat = '0;
   logic [LEN_W-1:0]   cfg_len = '0;
   logic               cfg_ovl = 1'b0;
   logic               cnt_clr = 1'b0;

   logic               match;
   logic [LANES-1:0]   match_vec;
   logic [CNT_W-1:0]   match_cnt;
   logic               cfg_err;

   logic               match3;
   logic [LANES-1:0]   match_vec3;
   logic [2:0]         match_cnt3;
   logic               cfg_err3;

   int errors = 0;
   int checks = 0;

   // Bit t of the reference stream is stream[23-t].
   logic [23:0] stream = 24'b011101110111001110001110;

   always #5 clk = ~clk;

   seq_detect_prog #(.LANES(LANES), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .clr(clr), .din_vld(din_vld), .din(din), .cfg_we(cfg_we),
      .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
      .match(match), .match_vec(match_vec), .match_cnt(match_cnt), .cfg_err(cfg_err)
   );

   seq_detect_prog #(.LANES(LANES), .MAX_LEN(MAX_LEN), .CNT_W(3)) dut3 (
      .clk(clk), .clr(clr), .din_vld(din_vld), .din(din), .cfg_we(cfg_we),
      .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
      .match(match3), .match_vec(match_vec3), .match_cnt(match_cnt3), .cfg_err(cfg_err3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      din_vld = 1'b0;
      din     = '0;
      cfg_we  = 1'b0;
      cnt_clr = 1'b0;
   endtask

   // Hand-derived per-cycle match_vec for the reference stream.
   function automatic logic [1:0] exp_vec(input int c, input bit ovl);
      case (c)
         2, 6:    exp_vec = 2'b10;
         4:       exp_vec = ovl ? 2'b10 : 2'b00;
         8, 11:   exp_vec = 2'b01;
         default: exp_vec = 2'b00;
      endcase
   endfunction

   task automatic test_reset();
      #1 clr = 1'b0;
      #2;
      checks++; if (match !== 1'b0) begin errors++; $display("FAIL reset_match got=%b exp=0", match); end
      checks++; if (match_vec !== 2'b00) begin errors++; $display("FAIL reset_match_vec got=%b exp=00", match_vec); end
      checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL reset_match_cnt got=%0d exp=0", match_cnt); end
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
      #19 clr = 1'b1;
      tick();
   endtask

   task automatic test_nonoverlap();
      logic [1:0] e;
      for (int c = 0; c < 12; c++) begin
         din_vld = 1'b1;
         din     = stream[23-2*c -: 2];
         tick();
         e = exp_vec(c, 1'b0);
         checks++; if (match_vec !== e) begin errors++; $display("FAIL nonovl_vec cyc=%0d got=%b exp=%b", c, match_vec, e); end
         checks++; if (match !== (|e)) begin errors++; $display("FAIL nonovl_match cyc=%0d got=%b exp=%b", c, match, |e); end
      end
      idle_inputs();
      checks++; if (match_cnt !== 8'd4) begin errors++; $display("FAIL nonovl_cnt got=%0d exp=4", match_cnt); end
   endtask

   task automatic test_overlap();
      logic [1:0] e;
      cfg_we = 1'b1; cfg_pat = 8'b00001110; cfg_len = 4'd5; cfg_ovl = 1'b1; cnt_clr = 1'b1;
      din_vld = 1'b1; din = 2'b11;
      tick();
      checks++; if (match_vec !== 2'b00) begin errors++; $display("FAIL cfg_discard_vec got=%b exp=00", match_vec); end
      checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL cfg_cnt_clr got=%0d exp=0", match_cnt); end
      idle_inputs();
      for (int c = 0; c < 12; c++) begin
         din_vld = 1'b1;
         din     = stream[23-2*c -: 2];
         tick();
         e = exp_vec(c, 1'b1);
         checks++; if (match_vec !== e) begin errors++; $display("FAIL ovl_vec cyc=%0d got=%b exp=%b", c, match_vec, e); end
      end
      idle_inputs();
      checks++; if (match_cnt !== 8'd5) begin errors++; $display("FAIL ovl_cnt got=%0d exp=5", match_cnt); end
   endtask

   task automatic test_len1();
      for (int m = 0; m < 2; m++) begin
         cfg_we = 1'b1; cfg_pat = 8'h01; cfg_len = 4'd1; cfg_ovl = (m == 0); cnt_clr = 1'b1;
         tick();
         idle_inputs();
         for (int i = 0; i < 3; i++) begin
            din_vld = 1'b1; din = 2'b11;
            tick();
            checks++; if (match_vec !== 2'b11) begin errors++; $display("FAIL len1_vec ovl=%0d cyc=%0d got=%b exp=11", (m == 0), i, match_vec); end
            checks++; if (match_cnt !== 8'(2*i+2)) begin errors++; $display("FAIL len1_cnt ovl=%0d cyc=%0d got=%0d exp=%0d", (m == 0), i, match_cnt, 2*i+2); end
         end
         idle_inputs();
      end
   endtask

   task automatic test_cfg_err();
      cfg_we = 1'b1; cfg_pat = 8'b00001110; cfg_len = 4'd5; cfg_ovl = 1'b0; cnt_clr = 1'b1;
      tick();
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL legal_cfg_err got=%b exp=0", cfg_err); end
      idle_inputs();
      din_vld = 1'b1; din = 2'b01; tick();
      din = 2'b11; tick();
      checks++; if (match_vec !== 2'b00) begin errors++; $display("FAIL prefix_vec got=%b exp=00", match_vec); end
      cfg_we = 1'b1; cfg_pat = 8'h01; cfg_len = 4'd0; cfg_ovl = 1'b1; din_vld = 1'b1; din = 2'b00;
      tick();
      checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL len0_err got=%b exp=1", cfg_err); end
      checks++; if (match_vec !== 2'b00) begin errors++; $display("FAIL len0_discard got=%b exp=00", match_vec); end
      idle_inputs();
      tick();
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL len0_pulse got=%b exp=0", cfg_err); end
      cfg_we = 1'b1; cfg_len = 4'(MAX_LEN+1); din_vld = 1'b1; din = 2'b00;
      tick();
      checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL lenmax_err got=%b exp=1", cfg_err); end
      idle_inputs();
      tick();
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL lenmax_pulse got=%b exp=0", cfg_err); end
      // History 0111 survived both rejected writes, so a trailing 0 completes 01110.
      din_vld = 1'b1; din = 2'b00;
      tick();
      checks++; if (match_vec !== 2'b10) begin errors++; $display("FAIL kept_hist_vec got=%b exp=10", match_vec); end
      for (int c = 0; c < 12; c++) begin
         din_vld = 1'b1; din = stream[23-2*c -: 2]; cnt_clr = (c == 0);
         tick();
         checks++; if (match_vec !== exp_vec(c, 1'b0)) begin errors++; $display("FAIL err_stream_vec cyc=%0d got=%b exp=%b", c, match_vec, exp_vec(c, 1'b0)); end
         din_vld = 1'b0; din = 2'b11; cnt_clr = 1'b0;
         tick();
         checks++; if (match_vec !== 2'b00) begin errors++; $display("FAIL gap_vec cyc=%0d got=%b exp=00", c, match_vec); end
      end
      idle_inputs();
      checks++; if (match_cnt !== 8'd4) begin errors++; $display("FAIL err_stream_cnt got=%0d exp=4", match_cnt); end
   endtask

   task automatic test_async_clr();
      cfg_we = 1'b1; cfg_pat = 8'b00001110; cfg_len = 4'd5; cfg_ovl = 1'b1;
      tick();
      idle_inputs();
      din_vld = 1'b1; din = 2'b01; tick();
      din = 2'b11; tick();
      checks++; if (match_cnt !== 8'd4) begin errors++; $display("FAIL preclr_cnt got=%0d exp=4", match_cnt); end
      #3 clr = 1'b0;
      #1;
      checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL clr_cnt got=%0d exp=0", match_cnt); end
      checks++; if (match !== 1'b0 || match_vec !== 2'b00 || cfg_err !== 1'b0) begin errors++; $display("FAIL clr_outs got=%b/%b/%b exp=0/00/0", match, match_vec, cfg_err); end
      #2 clr = 1'b1;
      din_vld = 1'b1; din = 2'b00;
      tick();
      checks++; if (match_vec !== 2'b00) begin errors++; $display("FAIL clr_nomatch got=%b exp=00", match_vec); end
      // Config returned to non-overlap: no bit-8 match.
      for (int c = 0; c < 12; c++) begin
         din_vld = 1'b1; din = stream[23-2*c -: 2];
         tick();
         checks++; if (match_vec !== exp_vec(c, 1'b0)) begin errors++; $display("FAIL clr_stream_vec cyc=%0d got=%b exp=%b", c, match_vec, exp_vec(c, 1'b0)); end
      end
      idle_inputs();
      checks++; if (match_cnt !== 8'd4) begin errors++; $display("FAIL clr_stream_cnt got=%0d exp=4", match_cnt); end
   endtask

   task automatic test_saturate();
      logic [2:0] sat_exp [5];
      sat_exp = '{3'd2, 3'd4, 3'd6, 3'd7, 3'd7};
      cfg_we = 1'b1; cfg_pat = 8'h01; cfg_len = 4'd1; cfg_ovl = 1'b0; cnt_clr = 1'b1;
      tick();
      idle_inputs();
      for (int i = 0; i < 5; i++) begin
         din_vld = 1'b1; din = 2'b11;
         tick();
         checks++; if (match_cnt3 !== sat_exp[i]) begin errors++; $display("FAIL sat_cnt cyc=%0d got=%0d exp=%0d", i, match_cnt3, sat_exp[i]); end
      end
      checks++; if (match_cnt !== 8'd10) begin errors++; $display("FAIL wide_cnt got=%0d exp=10", match_cnt); end
      din_vld = 1'b1; din = 2'b11; cnt_clr = 1'b1;
      tick();
      checks++; if (match_cnt3 !== 3'd2) begin errors++; $display("FAIL sat_clr got=%0d exp=2", match_cnt3); end
      idle_inputs();
      din_vld = 1'b1; din = 2'b11;
      tick();
      checks++; if (match_cnt3 !== 3'd4) begin errors++; $display("FAIL sat_after_clr got=%0d exp=4", match_cnt3); end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_nonoverlap();
      test_overlap();
      test_len1();
      test_cfg_err();
      test_async_clr();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
